// File: rtl/regfile_32x64.sv
// regfile_32x64: architectural integer register file, 32 x 64-bit.
// One write port (from WB) and two combinational read ports (to ID).
// The register at ZERO_REG reads as constant zero and ignores writes.
// A write-through bypass lets an ID read of the register being written
// in WB see the new value in the same cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset; clears all registers
//   reg_write  in   write enable for wr_addr/wr_data this cycle
//   wr_addr    in   destination register index
//   wr_data    in   data to write
//   rd_addr1   in   read port 1 index
//   rd_addr2   in   read port 2 index
//   rd_data1   out  read port 1 data (combinational)
//   rd_data2   out  read port 2 data (combinational)
module regfile_32x64 #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned N_REGS   = 32,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      reg_write,
    input  logic [$clog2(N_REGS)-1:0] wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [$clog2(N_REGS)-1:0] rd_addr1,
    input  logic [$clog2(N_REGS)-1:0] rd_addr2,
    output logic [DATA_W-1:0]         rd_data1,
    output logic [DATA_W-1:0]         rd_data2
);

    localparam int unsigned ADDR_W = $clog2(N_REGS);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [N_REGS-1:0][DATA_W-1:0] regs_q;
    logic [N_REGS-1:0][DATA_W-1:0] regs_d;

    logic write_en;
    logic bypass1;
    logic bypass2;

    // Writes to the zero register are dropped here, before the decoder.
    assign write_en = reg_write & (wr_addr != ZERO_ADDR);

    // Write decoder: only the addressed register takes wr_data.
    // The zero register's flop is kept at constant 0 and is optimised away.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < int'(N_REGS); i++) begin
            if (write_en && (wr_addr == ADDR_W'(i))) begin
                regs_d[i] = wr_data;
            end
        end
        regs_d[ZERO_REG] = '0;
    end

    // Storage; reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass is disabled while reset is asserted, because that write is lost.
    assign bypass1 = reg_write & ~reset & (wr_addr == rd_addr1) & (rd_addr1 != ZERO_ADDR);
    assign bypass2 = reg_write & ~reset & (wr_addr == rd_addr2) & (rd_addr2 != ZERO_ADDR);

    // Read port 1: 32:1 select, then bypass select, zero register forced last.
    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        if (bypass1) begin
            rd_data1 = wr_data;
        end
        if (rd_addr1 == ZERO_ADDR) begin
            rd_data1 = '0;
        end
    end

    // Read port 2: identical structure, fully independent of port 1.
    always_comb begin
        rd_data2 = regs_q[rd_addr2];
        if (bypass2) begin
            rd_data2 = wr_data;
        end
        if (rd_addr2 == ZERO_ADDR) begin
            rd_data2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_32x64.sv
// Directed testbench for regfile_32x64.
module tb_regfile_32x64;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [63:0] rd_data1;
    logic [63:0] rd_data2;

    int checks;
    int failures;

    logic [63:0] model [32];

    regfile_32x64 dut (
        .clk       (clk),
        .reset     (reset),
        .reg_write (reg_write),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pattern(input int i);
        return {32'hA5A5_0000 | 32'(i), 32'h0000_FFFF ^ 32'(i)};
    endfunction

    // Reads every address on both ports (port 2 walks in reverse) against the model.
    task automatic read_all(input string tag);
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a);
            rd_addr2 = 5'(31 - a);
            #1;
            check($sformatf("%s_p1_a%0d", tag, a), rd_data1, model[a]);
            check($sformatf("%s_p2_a%0d", tag, 31 - a), rd_data2, model[31 - a]);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        reg_write = 1'b0;
        wr_addr   = 5'd0;
        wr_data   = 64'h0;
        rd_addr1  = 5'd0;
        rd_addr2  = 5'd0;
        for (int i = 0; i < 32; i++) model[i] = 64'h0;

        // 1. One reset cycle, then every address reads zero on both ports.
        tick();
        reset = 1'b0;
        read_all("reset");

        // 2. Fill registers 0..30 with a distinct pattern, then read all back.
        for (int i = 0; i < 31; i++) begin
            reg_write = 1'b1;
            wr_addr   = 5'(i);
            wr_data   = pattern(i);
            tick();
            model[i] = pattern(i);
        end
        reg_write = 1'b0;
        read_all("fill");

        // 3. Same-cycle bypass on both ports, then value held via storage.
        reg_write = 1'b1;
        wr_addr   = 5'd5;
        wr_data   = 64'hDEAD_BEEF_0123_4567;
        rd_addr1  = 5'd5;
        rd_addr2  = 5'd5;
        #1;
        check("bypass_p1", rd_data1, 64'hDEAD_BEEF_0123_4567);
        check("bypass_p2", rd_data2, 64'hDEAD_BEEF_0123_4567);
        tick();
        model[5] = 64'hDEAD_BEEF_0123_4567;
        reg_write = 1'b0;
        #1;
        check("held_p1", rd_data1, 64'hDEAD_BEEF_0123_4567);
        check("held_p2", rd_data2, 64'hDEAD_BEEF_0123_4567);

        // 3b. Bypass on one port only; the other port reads storage.
        reg_write = 1'b1;
        wr_addr   = 5'd10;
        wr_data   = 64'h0BAD_F00D_CAFE_0010;
        rd_addr1  = 5'd10;
        rd_addr2  = 5'd11;
        #1;
        check("split_p1_bypass", rd_data1, 64'h0BAD_F00D_CAFE_0010);
        check("split_p2_store", rd_data2, pattern(11));
        rd_addr1 = 5'd11;
        rd_addr2 = 5'd10;
        #1;
        check("split_p1_store", rd_data1, pattern(11));
        check("split_p2_bypass", rd_data2, 64'h0BAD_F00D_CAFE_0010);
        tick();
        model[10] = 64'h0BAD_F00D_CAFE_0010;
        reg_write = 1'b0;

        // 4. Write to the zero register is discarded, no other register changes.
        reg_write = 1'b1;
        wr_addr   = 5'd31;
        wr_data   = 64'hFFFF_FFFF_FFFF_FFFF;
        rd_addr1  = 5'd31;
        rd_addr2  = 5'd31;
        #1;
        check("xzr_same_p1", rd_data1, 64'h0);
        check("xzr_same_p2", rd_data2, 64'h0);
        tick();
        reg_write = 1'b0;
        #1;
        check("xzr_after_p1", rd_data1, 64'h0);
        read_all("xzr");

        // 5. reg_write=0 with a matching address must not bypass or write.
        reg_write = 1'b1;
        wr_addr   = 5'd7;
        wr_data   = 64'h55;
        tick();
        model[7] = 64'h55;
        reg_write = 1'b0;
        wr_addr   = 5'd7;
        wr_data   = 64'h1234;
        rd_addr1  = 5'd7;
        #1;
        check("nowrite_same", rd_data1, 64'h55);
        tick();
        check("nowrite_after", rd_data1, 64'h55);

        // 6. Reset wins over a simultaneous write; bypass disabled during reset.
        reg_write = 1'b1;
        wr_addr   = 5'd3;
        wr_data   = 64'h77;
        tick();
        model[3] = 64'h77;
        reg_write = 1'b0;
        rd_addr1  = 5'd3;
        #1;
        check("pre_reset_r3", rd_data1, 64'h77);
        reset     = 1'b1;
        reg_write = 1'b1;
        wr_addr   = 5'd3;
        wr_data   = 64'h99;
        rd_addr1  = 5'd3;
        rd_addr2  = 5'd3;
        #1;
        check("reset_nobypass_p1", rd_data1, 64'h77);
        check("reset_nobypass_p2", rd_data2, 64'h77);
        tick();
        reset     = 1'b0;
        reg_write = 1'b0;
        #1;
        check("reset_lost_p1", rd_data1, 64'h0);
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        read_all("midreset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
